// File: rtl/mips_instr_encoder.sv
// Packs decoded operation descriptors into MIPS-I words and streams them into IMEM
// at consecutive word addresses; the LI pseudo-op expands to lui/ori when needed.
module mips_instr_encoder #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [31:0]       in_imm,
    output logic              im_we,
    output logic [31:0]       im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              overflow
);

    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [5:0]      OPC_ORI = 6'h0D;
    localparam logic [5:0]      OPC_LUI = 6'h0F;

    typedef enum logic {IDLE, EMIT2} state_t;

    state_t      state, state_next;
    logic [31:0] first_word, second_word, pend_word, wr_data;
    logic        two_words, wr_en, load_pend, set_ovf;
    logic [15:0] imm_hi, imm_lo;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {6'b0, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [5:0] alu_funct(input logic [4:0] op);
        case (op)
            5'd0:    return 6'h20;
            5'd1:    return 6'h21;
            5'd2:    return 6'h22;
            5'd3:    return 6'h23;
            5'd4:    return 6'h24;
            5'd5:    return 6'h25;
            5'd6:    return 6'h26;
            5'd7:    return 6'h27;
            5'd8:    return 6'h2A;
            5'd9:    return 6'h2B;
            5'd10:   return 6'h00;
            5'd11:   return 6'h02;
            5'd12:   return 6'h03;
            5'd13:   return 6'h04;
            5'd14:   return 6'h06;
            5'd15:   return 6'h07;
            default: return 6'h08;
        endcase
    endfunction

    function automatic logic [5:0] imm_opcode(input logic [4:0] op);
        case (op)
            5'd17:   return 6'h08;
            5'd18:   return 6'h09;
            5'd19:   return 6'h0C;
            5'd20:   return 6'h0D;
            5'd21:   return 6'h0E;
            5'd22:   return 6'h23;
            5'd23:   return 6'h2B;
            5'd24:   return 6'h04;
            5'd25:   return 6'h05;
            5'd26:   return 6'h0A;
            default: return 6'h0B;
        endcase
    endfunction

    assign imm_hi = in_imm[31:16];
    assign imm_lo = in_imm[15:0];
    assign full   = (word_count == DEPTH);

    always_comb begin
        first_word  = '0;
        second_word = i_word(OPC_ORI, in_rt, in_rt, imm_lo);
        two_words   = 1'b0;
        case (in_op) inside
            [5'd0:5'd9], [5'd13:5'd15]:
                first_word = r_word(in_rs, in_rt, in_rd, 5'd0, alu_funct(in_op));
            [5'd10:5'd12]:
                first_word = r_word(5'd0, in_rt, in_rd, in_shamt, alu_funct(in_op));
            5'd16:
                first_word = r_word(in_rs, 5'd0, 5'd0, 5'd0, alu_funct(in_op));
            [5'd17:5'd27]:
                first_word = i_word(imm_opcode(in_op), in_rs, in_rt, imm_lo);
            5'd28:
                first_word = i_word(OPC_LUI, 5'd0, in_rt, imm_lo);
            5'd29:
                first_word = {6'h02, in_imm[25:0]};
            5'd30:
                first_word = {6'h03, in_imm[25:0]};
            default: begin
                // LI: a zero half lets a single instruction carry the constant
                if (imm_hi == 16'h0) begin
                    first_word = i_word(OPC_ORI, 5'd0, in_rt, imm_lo);
                end else begin
                    first_word = i_word(OPC_LUI, 5'd0, in_rt, imm_hi);
                    two_words  = (imm_lo != 16'h0);
                end
            end
        endcase
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        wr_data    = first_word;
        load_pend  = 1'b0;
        set_ovf    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !full;
                if (in_valid && !full) begin
                    wr_en = 1'b1;
                    if (two_words) begin
                        load_pend  = 1'b1;
                        state_next = EMIT2;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                if (full) begin
                    set_ovf = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_data = pend_word;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_we      <= 1'b0;
            im_addr    <= BASE_ADDR;
            im_wdata   <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            pend_word  <= '0;
        end else begin
            im_we <= wr_en;
            // wr_en is never raised while full, so the count cannot pass DEPTH
            if (wr_en) begin
                im_addr    <= BASE_ADDR + {{(29-ADDR_W){1'b0}}, word_count, 2'b00};
                im_wdata   <= wr_data;
                word_count <= word_count + (ADDR_W+1)'(1);
            end
            if (load_pend) pend_word <= second_word;
            if (set_ovf)   overflow  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomized and directed bench for mips_instr_encoder against a queue-based
// model of the expected IMEM write stream; a 4-word instance covers full/overflow.
module tb_mips_instr_encoder;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk, rst, in_valid;
    logic [4:0]  in_op, in_rs, in_rt, in_rd, in_shamt;
    logic [31:0] in_imm;

    logic        b_ready, b_we, b_full, b_ovf;
    logic [31:0] b_addr, b_wdata;
    logic [10:0] b_cnt;
    logic        s_ready, s_we, s_full, s_ovf;
    logic [31:0] s_addr, s_wdata;
    logic [2:0]  s_cnt;

    mips_instr_encoder #(.ADDR_W(10), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .im_we(b_we), .im_addr(b_addr),
        .im_wdata(b_wdata), .word_count(b_cnt), .full(b_full), .overflow(b_ovf)
    );

    mips_instr_encoder #(.ADDR_W(2), .BASE_ADDR(BASE)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .im_we(s_we), .im_addr(s_addr),
        .im_wdata(s_wdata), .word_count(s_cnt), .full(s_full), .overflow(s_ovf)
    );

    logic        use_small;
    logic        obs_we, obs_ready, obs_full, obs_ovf;
    logic [31:0] obs_addr, obs_wdata, obs_cnt;

    assign obs_we    = use_small ? s_we    : b_we;
    assign obs_ready = use_small ? s_ready : b_ready;
    assign obs_full  = use_small ? s_full  : b_full;
    assign obs_ovf   = use_small ? s_ovf   : b_ovf;
    assign obs_addr  = use_small ? s_addr  : b_addr;
    assign obs_wdata = use_small ? s_wdata : b_wdata;
    assign obs_cnt   = use_small ? 32'(s_cnt) : 32'(b_cnt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model state: pending writes (bit 32 marks a word dropped for lack of space)
    logic [32:0] exp_q[$];
    int          nw;
    int          depth;
    bit          exp_ovf;
    bit          exp_ready;

    int funct_tab[17] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7, 8};
    int opc_tab[14]   = '{8, 9, 12, 13, 14, 35, 43, 4, 5, 10, 11, 15, 2, 3};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        if (nw + exp_q.size() >= depth) exp_q.push_back({1'b1, 32'h0});
        else                            exp_q.push_back({1'b0, w});
    endtask

    function automatic logic [31:0] fields(input int opc, input int rs, input int rt, input int low);
        return (opc * 32'h0400_0000) + (rs * 32'h0020_0000) + (rt * 32'h0001_0000) + low;
    endfunction

    task automatic model_push(input int op, input int rs, input int rt, input int rd,
                              input int sh, input logic [31:0] imm);
        int hi, lo;
        hi = int'(imm / 32'h10000);
        lo = int'(imm % 32'h10000);
        if (op >= 10 && op <= 12)
            push_word(fields(0, 0, rt, rd * 2048 + sh * 64 + funct_tab[op]));
        else if (op == 16)
            push_word(fields(0, rs, 0, funct_tab[op]));
        else if (op < 16)
            push_word(fields(0, rs, rt, rd * 2048 + funct_tab[op]));
        else if (op <= 27)
            push_word(fields(opc_tab[op-17], rs, rt, lo));
        else if (op == 28)
            push_word(fields(15, 0, rt, lo));
        else if (op <= 30)
            push_word(opc_tab[op-17] * 32'h0400_0000 + (imm % 32'h0400_0000));
        else if (hi == 0)
            push_word(fields(13, 0, rt, lo));
        else if (lo == 0)
            push_word(fields(15, 0, rt, hi));
        else begin
            push_word(fields(15, 0, rt, hi));
            push_word(fields(13, rt, rt, lo));
        end
    endtask

    task automatic offer(input bit v, input logic [4:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                         input logic [31:0] imm);
        in_valid = v; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_imm = imm;
        if (v && exp_ready && !rst) model_push(op, rs, rt, rd, sh, imm);
    endtask

    task automatic idle();
        offer(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    endtask

    task automatic tick();
        logic [32:0] e;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            nw = 0;
            exp_ovf = 0;
            check_val("rst_we", 32'(obs_we), 32'h0);
            check_val("rst_addr", obs_addr, BASE);
            check_val("rst_wdata", obs_wdata, 32'h0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[32]) begin
                exp_ovf = 1;
                check_val("drop_we", 32'(obs_we), 32'h0);
            end else begin
                check_val("we", 32'(obs_we), 32'h1);
                check_val("wdata", obs_wdata, e[31:0]);
                check_val("addr", obs_addr, BASE + 32'(nw * 4));
                nw++;
            end
        end else begin
            check_val("idle_we", 32'(obs_we), 32'h0);
        end
        check_val("count", obs_cnt, 32'(nw));
        check_val("full", 32'(obs_full), 32'(nw == depth));
        check_val("ovf", 32'(obs_ovf), 32'(exp_ovf));
        exp_ready = (exp_q.size() == 0) && (nw != depth);
        check_val("ready", 32'(obs_ready), 32'(exp_ready));
    endtask

    task automatic reset_all();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] imm;
        logic [15:0] r16;
        use_small = 1'b0;
        depth     = 1024;
        nw        = 0;
        exp_ovf   = 0;
        exp_ready = 0;
        rst       = 1'b1;
        idle();
        tick();
        rst = 1'b0;

        // single R-type add
        offer(1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
        tick();
        check_val("add_word", obs_wdata, 32'h0022_1820);
        check_val("add_addr", obs_addr, 32'h0040_0000);
        check_val("add_cnt", obs_cnt, 32'd1);
        idle();
        tick();

        // back-to-back mixed stream
        reset_all();
        offer(1'b1, 5'd10, 5'd7, 5'd1, 5'd2, 5'd4, 32'h0);
        tick();
        check_val("sll_word", obs_wdata, 32'h0001_1100);
        check_val("sll_addr", obs_addr, 32'h0040_0000);
        offer(1'b1, 5'd17, 5'd0, 5'd5, 5'd0, 5'd0, 32'h0000_FFFF);
        tick();
        check_val("addi_word", obs_wdata, 32'h2005_FFFF);
        check_val("addi_addr", obs_addr, 32'h0040_0004);
        offer(1'b1, 5'd29, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0010_0000);
        tick();
        check_val("j_word", obs_wdata, 32'h0810_0000);
        check_val("j_addr", obs_addr, 32'h0040_0008);
        idle();
        tick();

        // two-word and one-word LI
        reset_all();
        offer(1'b1, 5'd31, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234_5678);
        tick();
        check_val("li2_lui", obs_wdata, 32'h3C08_1234);
        check_val("li2_ready", 32'(obs_ready), 32'h0);
        idle();
        tick();
        check_val("li2_ori", obs_wdata, 32'h3508_5678);
        check_val("li2_addr", obs_addr, 32'h0040_0004);
        offer(1'b1, 5'd31, 5'd0, 5'd8, 5'd0, 5'd0, 32'h0000_5678);
        tick();
        check_val("li_lo_word", obs_wdata, 32'h3408_5678);
        offer(1'b1, 5'd31, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234_0000);
        tick();
        check_val("li_hi_word", obs_wdata, 32'h3C08_1234);
        idle();
        tick();

        // reset in EMIT2 abandons the ori; a descriptor offered during reset is ignored
        reset_all();
        offer(1'b1, 5'd31, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234_5678);
        tick();
        rst = 1'b1;
        offer(1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
        tick();
        rst = 1'b0;
        idle();
        tick();
        check_val("midli_cnt", obs_cnt, 32'h0);
        check_val("midli_ready", 32'(obs_ready), 32'h1);

        // randomized stream
        reset_all();
        for (int i = 0; i < 400; i++) begin
            r16 = 16'($urandom);
            case ($urandom % 3)
                0:       imm = $urandom;
                1:       imm = {16'h0, r16};
                default: imm = {r16, 16'h0};
            endcase
            offer(($urandom % 4) != 0, 5'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 5'($urandom), imm);
            tick();
        end
        idle();
        tick();
        tick();

        // fill a 4-word memory and overflow on the LI second word
        use_small = 1'b1;
        depth     = 4;
        reset_all();
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 5'd1, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 32'h0);
            tick();
        end
        offer(1'b1, 5'd31, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234_5678);
        tick();
        check_val("ovf_lui", obs_wdata, 32'h3C08_1234);
        idle();
        tick();
        check_val("ovf_flag", 32'(obs_ovf), 32'h1);
        check_val("ovf_full", 32'(obs_full), 32'h1);
        check_val("ovf_ready", 32'(obs_ready), 32'h0);
        check_val("ovf_cnt", obs_cnt, 32'd4);
        offer(1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
        tick();
        check_val("ovf_nowrite", 32'(obs_we), 32'h0);
        idle();
        tick();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
